data_mem_sized: RTL and testbench
=================================

Name: data_mem_sized

Overview:
Parametrised data memory for the single-cycle/multi-cycle CPU datapath. It replaces the fixed 32-word, word-only RAM and adds the following:
- byte, halfword and word access with sign or zero extension;
- a registered read with a valid strobe;
- misalignment error reporting;
- a hardware clear sequence after reset.

It sits between the ALU address output and the writeback mux, alongside the instruction memory.

Parameters:
ADDR_W, 32, width of the byte address input.
DEPTH_LOG2, 5, log2 of the number of 32-bit words (default 32 words).
CLEAR_ON_RESET, 1, when 1, memory is zeroed word by word after reset; when 0, the CLEAR state is skipped.

Ports:
Clock  input  1  system clock, rising edge.
Resetn  input  1  asynchronous active-low reset.
req  input  1  access request.
we  input  1  1 = store, 0 = load; sampled with req.
size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
addr  input  ADDR_W  byte address.
datain  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
ready  output  1  request accepted on this edge when req && ready.
dataout  output  32  load result, registered.
rvalid  output  1  one-cycle pulse: dataout is valid.
err  output  1  one-cycle pulse: the accepted request was misaligned or illegal.
busy  output  1  high while the clear sequence runs.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - state=CLEAR if CLEAR_ON_RESET else IDLE;
  - clear counter=0;
  - ready=0, rvalid=0, err=0, dataout=0;
  - busy=CLEAR_ON_RESET.
  - Memory contents are not reset asynchronously.
- CLEAR state: one word is written to 0 per cycle at index = counter. counter increments each cycle. After index 2^DEPTH_LOG2-1 is written, the next state is IDLE and busy drops in the same edge. Reset asserted mid-clear restarts the sequence at index 0.
- IDLE state: ready=1 combinationally. One request is accepted per cycle; back-to-back requests run at full rate with no bubbles.
- Word index = addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses alias modulo 4*2^DEPTH_LOG2 bytes. Lane = addr[1:0], little-endian (lane 0 = bits [7:0]).
- Alignment check:
  - halfword requires addr[0]=0;
  - word requires addr[1:0]=00;
  - size=11 is always illegal.
- Store, legal: on the accepting edge, only the addressed lanes are written:
  - byte → lane addr[1:0] ← datain[7:0];
  - half → lanes {addr[1],0} and {addr[1],1} ← datain[15:0];
  - word → all four lanes.
  - No rvalid pulse.
- Store, misaligned/illegal: memory is unchanged; err=1 for the following cycle; rvalid=0.
- Load, legal: the word is read at the accepting edge. On the next edge, dataout = extracted lane(s) shifted to bit 0, extended per sign/size, and rvalid=1 for one cycle. Latency is exactly 1 cycle.
- Load, misaligned/illegal: next cycle rvalid=1, err=1, dataout=0.
- dataout holds its last value when rvalid=0.
- Store followed by a load to the same word on the next cycle returns the new data (write completes before the read edge).
- req while busy (CLEAR): ignored. No response is generated and no write occurs.
- Reset asserted while a load response is pending: the response is dropped (rvalid stays 0).

Test Plan:
- Reset then clear, DEPTH_LOG2=5: Resetn low 2 cycles then high → busy=1 for exactly 32 cycles, ready=0 throughout. Then ready=1. A word load from addr 0x7C gives dataout=0x00000000, rvalid 1 cycle after accept.
- Word store then byte loads: store 0x8012F0A5 @0x10. Then:
  - lb @0x10 → 0xFFFFFFA5;
  - lbu @0x13 → 0x00000080;
  - lh @0x12 → 0xFFFF8012;
  - lhu @0x10 → 0x0000F0A5.
  Each response arrives one cycle after its request, issued back-to-back.
- Byte/half merge: store word 0x11223344 @0x20, sb 0xAA @0x21, sh 0xBEEF @0x22 → word load @0x20 returns 0xBEEFAA44.
- Misalignment:
  - sw @0x06 → err=1 for 1 cycle, rvalid=0; a subsequent lw @0x04 shows the original data unchanged.
  - lh @0x05 → rvalid=1, err=1, dataout=0.
  - size=11 → err=1.
- Aliasing and reset mid-clear:
  - store 0xDEADBEEF @0x84 → lw @0x04 returns 0xDEADBEEF;
  - Resetn pulsed low at clear cycle 10 → busy again lasts a full 32 cycles from release.
- Req during busy: req with sw 0x5 @0x0 while busy → no err, no rvalid. After clear, lw @0x0 returns 0.

Source files
------------

// File: rtl/data_mem_sized.sv
// Parametrised byte/half/word data memory with a registered load path,
// misalignment reporting and an optional word-by-word clear after reset.
module data_mem_sized #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DEPTH_LOG2     = 5,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       datain,
  output logic              ready,
  output logic [31:0]       dataout,
  output logic              rvalid,
  output logic              err,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [31:0]           dout_q, dout_d;

  logic [31:0]           mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  accept;
  logic                  misalign;
  logic                  store_we;
  logic                  clear_we;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           rword;
  logic [31:0]           shifted;
  logic [31:0]           ldata;

  // Upper address bits only alias; they carry no information here.
  if (ADDR_W > DEPTH_LOG2 + 2) begin : g_unused_addr
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2+2];
  end

  assign idx      = addr[DEPTH_LOG2+1:2];
  assign lane     = addr[1:0];
  assign ready    = (state_q == S_IDLE) && Resetn;
  assign busy     = (state_q == S_CLEAR);
  assign accept   = req && ready;
  assign clear_we = (state_q == S_CLEAR);
  assign store_we = accept && we && !misalign;

  always_comb begin
    misalign = 1'b0;
    unique case (size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr[0];
      2'b10:   misalign = |addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = '0;
    wdata = datain;
    unique case (size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{datain[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << {lane[1], 1'b0};
        wdata = {2{datain[15:0]}};
      end
      2'b10:   be = '1;
      default: be = '0;
    endcase
  end

  assign rword   = mem[idx];
  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    ldata = '0;
    unique case (size)
      2'b00:   ldata = {{24{sign & shifted[7]}}, shifted[7:0]};
      2'b01:   ldata = {{16{sign & shifted[15]}}, shifted[15:0]};
      2'b10:   ldata = rword;
      default: ldata = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    dout_d   = dout_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = S_IDLE;
      end
    end
    if (accept) begin
      err_d    = misalign;
      rvalid_d = !we;
      if (!we) begin
        dout_d = misalign ? '0 : ldata;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (clear_we) begin
      mem[cnt_q] <= '0;
    end else if (store_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign dataout = dout_q;
  assign rvalid  = rvalid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed bench for data_mem_sized: clear sequence, sized loads/stores,
// lane merging, misalignment, aliasing and reset/busy interactions.
module tb_data_mem_sized;

  logic        Clock;
  logic        Resetn;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] datain;
  logic        ready;
  logic [31:0] dataout;
  logic        rvalid;
  logic        err;
  logic        busy;

  int          checks;
  int          errors;
  logic [31:0] hold;

  data_mem_sized #(
    .ADDR_W        (32),
    .DEPTH_LOG2    (5),
    .CLEAR_ON_RESET(1)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .req    (req),
    .we     (we),
    .size   (size),
    .sign   (sign),
    .addr   (addr),
    .datain (datain),
    .ready  (ready),
    .dataout(dataout),
    .rvalid (rvalid),
    .err    (err),
    .busy   (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Presents one request, then samples the response just after the accepting edge.
  task automatic xfer(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic exp_err, input logic [31:0] exp_d);
    req    = 1'b1;
    we     = w;
    size   = sz;
    sign   = sg;
    addr   = a;
    datain = d;
    chk({tag, ".ready"}, {31'b0, ready}, 32'd1);
    @(posedge Clock);
    #1;
    chk({tag, ".rvalid"}, {31'b0, rvalid}, {31'b0, !w});
    chk({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    if (!w) hold = exp_d;
    chk({tag, ".data"}, dataout, hold);
  endtask

  task automatic idle(input string tag);
    req = 1'b0;
    @(posedge Clock);
    #1;
    chk({tag, ".rvalid"}, {31'b0, rvalid}, 32'd0);
    chk({tag, ".err"}, {31'b0, err}, 32'd0);
  endtask

  // Counts clear edges; holds req asserted for the first req_cycles edges.
  task automatic wait_clear(input int req_cycles, output int n, output logic bad);
    n   = 0;
    bad = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      if (n == req_cycles) req = 1'b0;
      if (ready !== 1'b0 || rvalid !== 1'b0 || err !== 1'b0) bad = 1'b1;
      @(posedge Clock);
      #1;
      n++;
    end
    req = 1'b0;
  endtask

  int   ncyc;
  logic bad;

  initial begin
    checks = 0;
    errors = 0;
    hold   = '0;
    Resetn = 1'b0;
    req    = 1'b0;
    we     = 1'b0;
    size   = 2'b00;
    sign   = 1'b0;
    addr   = '0;
    datain = '0;

    #1;
    chk("rst.ready", {31'b0, ready}, 32'd0);
    chk("rst.rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst.err", {31'b0, err}, 32'd0);
    chk("rst.dataout", dataout, 32'd0);
    chk("rst.busy", {31'b0, busy}, 32'd1);

    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b1;
    wait_clear(0, ncyc, bad);
    chk("clear.len", ncyc, 32'd32);
    chk("clear.quiet", {31'b0, bad}, 32'd0);
    chk("clear.ready", {31'b0, ready}, 32'd1);

    xfer("lw7c", 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 1'b0, 32'h00000000);

    xfer("sw10",  1'b1, 2'b10, 1'b0, 32'h10, 32'h8012F0A5, 1'b0, 32'h0);
    xfer("lb10",  1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 32'hFFFFFFA5);
    xfer("lbu13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'h00000080);
    xfer("lh12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFF8012);
    xfer("lhu10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000F0A5);
    idle("gap1");
    chk("hold", dataout, 32'h0000F0A5);

    xfer("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1'b0, 32'h0);
    xfer("sb21", 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 1'b0, 32'h0);
    xfer("sh22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 1'b0, 32'h0);
    xfer("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 32'hBEEFAA44);
    idle("gap2");

    xfer("sw04",   1'b1, 2'b10, 1'b0, 32'h04, 32'h01020304, 1'b0, 32'h0);
    xfer("sw06",   1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF, 1'b1, 32'h0);
    xfer("lw04",   1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0, 32'h01020304);
    xfer("lh05",   1'b0, 2'b01, 1'b1, 32'h05, 32'h0, 1'b1, 32'h00000000);
    idle("errpulse");
    xfer("ld11",   1'b0, 2'b11, 1'b0, 32'h08, 32'h0, 1'b1, 32'h00000000);
    xfer("st11",   1'b1, 2'b11, 1'b0, 32'h08, 32'hCAFEF00D, 1'b1, 32'h0);
    xfer("lw08",   1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 1'b0, 32'h00000000);
    idle("gap3");

    xfer("sw84", 1'b1, 2'b10, 1'b0, 32'h84, 32'hDEADBEEF, 1'b0, 32'h0);
    xfer("lw04a", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0, 32'hDEADBEEF);
    xfer("lb87",  1'b0, 2'b00, 1'b1, 32'h87, 32'h0, 1'b0, 32'hFFFFFFDE);
    idle("gap4");

    Resetn = 1'b0;
    #2 Resetn = 1'b1;
    repeat (10) @(posedge Clock);
    #1 Resetn = 1'b0;
    #2;
    chk("midclr.busy", {31'b0, busy}, 32'd1);
    Resetn = 1'b1;
    wait_clear(0, ncyc, bad);
    chk("midclr.len", ncyc, 32'd32);
    chk("midclr.quiet", {31'b0, bad}, 32'd0);
    xfer("lw10z", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h00000000);
    xfer("sw00", 1'b1, 2'b10, 1'b0, 32'h00, 32'h12345678, 1'b0, 32'h0);
    xfer("lw00", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, 32'h12345678);

    // Load accepted at the last edge; reset now must drop its response.
    #1 Resetn = 1'b0;
    req = 1'b0;
    #1;
    chk("drop.rvalid", {31'b0, rvalid}, 32'd0);
    chk("drop.dataout", dataout, 32'd0);
    hold = '0;

    req    = 1'b1;
    we     = 1'b1;
    size   = 2'b10;
    addr   = 32'h0;
    datain = 32'h5;
    #2 Resetn = 1'b1;
    wait_clear(5, ncyc, bad);
    chk("busyreq.len", ncyc, 32'd32);
    chk("busyreq.quiet", {31'b0, bad}, 32'd0);
    xfer("lw00z", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, 32'h00000000);
    idle("end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
